// File: rtl/muxed_register_scheduler.sv
// Two-requester scheduler loading one shared registered output behind a valid/ready stage.
// Build option: define MUX_SCHED_ROUND_ROBIN_EN for round-robin tie breaking (default: requester 1 wins ties).
module muxed_register_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt1,
    input  logic             req2,
    input  logic [WIDTH-1:0] d2,
    output logic             gnt2,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
    output logic             q_src,
    input  logic             q_ready,
    output logic             state_dbg
);

    // Handshake: a transfer happens on any edge where valid && ready; a requester
    // holds req/data stable until its gnt is seen high, and the consumer takes
    // q_out on any edge where q_valid && q_ready.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic             q_src_q, q_src_d;
    logic             load_ok;
    logic             tie_to_2;
    logic             data_select;

`ifdef MUX_SCHED_ROUND_ROBIN_EN
    // Holds the index of the last granted requester; reset to 1 so requester 1 wins the first tie.
    logic last_q, last_d;

    assign tie_to_2 = (last_q == 1'b0);

    always_comb begin
        last_d = last_q;
        if (gnt1) begin
            last_d = 1'b0;
        end else if (gnt2) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_to_2 = 1'b0;
`endif

    assign q_valid     = (state_q == FULL);
    assign load_ok     = !q_valid || q_ready;
    assign data_select = gnt1;

    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (!rst && load_ok) begin
            if (req1 && req2) begin
                gnt1 = !tie_to_2;
                gnt2 = tie_to_2;
            end else begin
                gnt1 = req1;
                gnt2 = req2;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        q_out_d = q_out_q;
        q_src_d = q_src_q;
        if (gnt1 || gnt2) begin
            state_d = FULL;
            q_out_d = data_select ? d1 : d2;
            q_src_d = gnt2;
        end else if (q_valid && q_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            q_out_q <= '0;
            q_src_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_out_q <= q_out_d;
            q_src_q <= q_src_d;
        end
    end

    assign q_out     = q_out_q;
    assign q_src     = q_src_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_muxed_register_scheduler.sv
// Directed self-checking bench for muxed_register_scheduler (either tie-break build).
module tb_muxed_register_scheduler;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             req1, req2;
    logic [WIDTH-1:0] d1, d2;
    logic             gnt1, gnt2;
    logic [WIDTH-1:0] q_out;
    logic             q_valid;
    logic             q_src;
    logic             q_ready;
    logic             state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    muxed_register_scheduler #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req1      (req1),
        .d1        (d1),
        .gnt1      (gnt1),
        .req2      (req2),
        .d2        (d2),
        .gnt2      (gnt2),
        .q_out     (q_out),
        .q_valid   (q_valid),
        .q_src     (q_src),
        .q_ready   (q_ready),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [3:0] exp_q_out;
    logic       exp_g1;

    initial begin
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; d1 = '0; d2 = '0; q_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        check("reset_q_valid", {7'd0, q_valid}, 8'd0);
        check("reset_q_out", {4'd0, q_out}, 8'd0);
        check("reset_state", {7'd0, state_dbg}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("idle_gnt1", {7'd0, gnt1}, 8'd0);
            check("idle_gnt2", {7'd0, gnt2}, 8'd0);
            step();
            check("idle_q_valid", {7'd0, q_valid}, 8'd0);
        end

        // Single request from requester 1
        req1 = 1'b1; d1 = 4'hA;
        settle();
        check("single_gnt1", {7'd0, gnt1}, 8'd1);
        check("single_gnt2", {7'd0, gnt2}, 8'd0);
        step();
        req1 = 1'b0;
        check("single_q_out", {4'd0, q_out}, 8'h0A);
        check("single_q_valid", {7'd0, q_valid}, 8'd1);
        check("single_q_src", {7'd0, q_src}, 8'd0);
        step();
        check("single_drain_q_valid", {7'd0, q_valid}, 8'd0);
        check("single_hold_q_out", {4'd0, q_out}, 8'h0A);

        // Fresh reset so the tie pointer starts at requester 1
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Continuous contention
        req1 = 1'b1; req2 = 1'b1; d1 = 4'h3; d2 = 4'hC;
        for (int i = 0; i < 4; i++) begin
`ifdef MUX_SCHED_ROUND_ROBIN_EN
            exp_g1 = (i % 2 == 0);
`else
            exp_g1 = 1'b1;
`endif
            exp_q_out = exp_g1 ? 4'h3 : 4'hC;
            settle();
            check("tie_gnt1", {7'd0, gnt1}, {7'd0, exp_g1});
            check("tie_gnt2", {7'd0, gnt2}, {7'd0, !exp_g1});
            step();
            check("tie_q_out", {4'd0, q_out}, {4'd0, exp_q_out});
            check("tie_q_src", {7'd0, q_src}, {7'd0, !exp_g1});
            check("tie_q_valid", {7'd0, q_valid}, 8'd1);
        end

        // Drain without refill
        req1 = 1'b0; req2 = 1'b0;
        settle();
        check("drain_no_gnt", {6'd0, gnt1, gnt2}, 8'd0);
        step();
        check("drain_q_valid", {7'd0, q_valid}, 8'd0);
        check("drain_q_out_hold", {4'd0, q_out}, {4'd0, exp_q_out});
        check("drain_state", {7'd0, state_dbg}, 8'd0);

        // Back-pressure
        req1 = 1'b1; d1 = 4'h5;
        step();
        req1 = 1'b0;
        check("bp_load_q_out", {4'd0, q_out}, 8'h05);
        req2 = 1'b1; d2 = 4'h9; q_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_gnt2_stalled", {7'd0, gnt2}, 8'd0);
            check("bp_gnt1_stalled", {7'd0, gnt1}, 8'd0);
            step();
            check("bp_q_out_stable", {4'd0, q_out}, 8'h05);
            check("bp_q_valid_stable", {7'd0, q_valid}, 8'd1);
            check("bp_q_src_stable", {7'd0, q_src}, 8'd0);
        end
        q_ready = 1'b1;
        settle();
        check("bp_release_gnt2", {7'd0, gnt2}, 8'd1);
        step();
        req2 = 1'b0;
        check("bp_release_q_out", {4'd0, q_out}, 8'h09);
        check("bp_release_q_src", {7'd0, q_src}, 8'd1);
        check("bp_release_q_valid", {7'd0, q_valid}, 8'd1);

        // Reset while FULL with a pending request
        req1 = 1'b1; d1 = 4'h7; rst = 1'b1;
        settle();
        check("rst_cycle_gnt1", {7'd0, gnt1}, 8'd0);
        step();
        rst = 1'b0;
        check("rst_full_q_valid", {7'd0, q_valid}, 8'd0);
        check("rst_full_q_out", {4'd0, q_out}, 8'd0);
        check("rst_full_q_src", {7'd0, q_src}, 8'd0);
        req2 = 1'b1; d2 = 4'h2;
        settle();
        check("post_rst_tie_gnt1", {7'd0, gnt1}, 8'd1);
        check("post_rst_tie_gnt2", {7'd0, gnt2}, 8'd0);
        step();
        req1 = 1'b0; req2 = 1'b0;
        check("post_rst_q_out", {4'd0, q_out}, 8'h07);
        check("post_rst_q_src", {7'd0, q_src}, 8'd0);
        step();
        check("final_q_valid", {7'd0, q_valid}, 8'd0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muxed_register_scheduler.md
# muxed_register_scheduler

Two-requester scheduler that shares one WIDTH-bit muxed output register between two sources. Each source presents data with a valid/ready handshake. The block arbitrates between them, drives the mux select, and loads the winner into the register. The registered result goes downstream through a valid/ready output stage. It sits between producer logic and any consumer that needs a single registered data stream selected from two inputs.

## Interface
- WIDTH, 4, data width of both inputs and the output register
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req1  input  1  requester 1 has valid data on d1
- d1  input  WIDTH  requester 1 data
- gnt1  output  1  requester 1 data accepted this cycle (combinational)
- req2  input  1  requester 2 has valid data on d2
- d2  input  WIDTH  requester 2 data
- gnt2  output  1  requester 2 data accepted this cycle (combinational)
- q_out  output  WIDTH  registered selected data
- q_valid  output  1  q_out holds unconsumed data
- q_src  output  1  source of q_out: 0 = requester 1, 1 = requester 2
- q_ready  input  1  consumer accepts q_out when q_valid && q_ready

## Operation
- State machine has two states.
  - EMPTY: q_valid=0.
  - FULL: q_valid=1.
- Load enable: load_ok = !q_valid || q_ready. The register can be refilled in the same cycle it drains.
- Arbitration is evaluated only when load_ok=1.
  - Only req1 high: gnt1=1.
  - Only req2 high: gnt2=1.
  - Both high: the winner follows the configured policy (see Configuration).
  - No request: no grant.
- gnt1 and gnt2 are never both 1. Both are 0 whenever load_ok=0 or rst=1.
- On a grant, at the next clock edge:
  - q_out <= d1 if gnt1, else d2; data_select = gnt1.
  - q_src <= grant index.
  - q_valid <= 1.
  - The last-grant pointer updates to the grant index.
- No grant while q_valid && q_ready: q_valid <= 0, FULL -> EMPTY. q_out and q_src hold their last values.
- q_valid && !q_ready: FULL holds. q_out, q_src and q_valid are stable, and no grant is issued.
- Requesters must keep req and d stable until granted. The block never drops a presented request.
- Reset values: q_out=0, q_valid=0, q_src=0, state=EMPTY, last-grant pointer=1 (requester 1 wins the first tie).
- Reset mid-operation discards the held data. No grant is issued in the reset cycle.

## Timing
- Latency from grant to q_valid is 1 cycle.
- Sustained throughput is one transfer per cycle while q_ready=1.
- gnt1 and gnt2 depend combinationally on req1, req2, q_valid, q_ready and the pointer. There is no combinational path from d1 or d2 to any output.
- Simultaneous drain and load: q_valid stays 1 and q_out changes to the new data on the same edge.
- Back-pressure: a stall propagates to the grants in the same cycle q_ready falls.

## Configuration
- MUX_SCHED_ROUND_ROBIN_EN
  - Defined: ties go to the requester not granted last. A requester holding req waits at most one transfer under continuous contention.
  - Undefined: fixed priority. Requester 1 always wins ties, and the last-grant pointer is unused. Requester 2 can starve.

## Test plan
- Reset, then idle: q_valid=0, q_out=0, and gnt1=gnt2=0 for 5 cycles.
- req1 only, d1=4'hA, q_ready=1: gnt1=1 in cycle 0. q_out=4'hA, q_valid=1 and q_src=0 in cycle 1. q_valid=0 in cycle 2.
- req1 and req2 both held, d1=4'h3, d2=4'hC, q_ready=1, round-robin build: grants alternate 1,2,1,2 and q_out runs 3,C,3,C. In the fixed-priority build, gnt1=1 every cycle and gnt2=0.
- Back-pressure: load 4'h5, hold q_ready=0 for 3 cycles with req2 high. gnt2=0 throughout and q_out stays 4'h5. When q_ready=1, gnt2 fires in that cycle and q_out=d2 in the next.
- Drain without refill: q_valid=1, q_ready=1, no requests. q_valid falls next cycle and q_out holds its value.
- Reset while FULL with req1 high: q_valid=0 and q_out=0 after the edge. gnt1=0 during the reset cycle. After reset releases, requester 1 wins a tie first.
